// File: rtl/shift_sched.sv
`timescale 1ns/1ps
// shift_sched: one multi-cycle shifter shared by two requesters.
//
// A two-way round-robin arbiter accepts one operation at a time. The engine
// then moves the operand up to STEP bit positions per cycle until the shift
// amount is used up. The result is held until the consumer takes it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (N = 0, 1)
//   reqN_op                    00 SLL, 01 SRL, 10 SRA, 11 ROL
//   reqN_a, reqN_shamt         operand and shift amount
//   res_valid / res_ready      result handshake
//   res_data, res_tag          shifted value and the index of its requester
//   busy                       engine is not idle (state != IDLE)
//
// Handshake semantics (all three channels): a transfer happens on a rising
// edge where valid && ready are both high. The producer may drop valid
// without a transfer. reqN_ready depends combinationally on the valids. It is
// high only in IDLE, and only for the granted requester. res_valid is high
// for exactly as long as the engine is in DONE.
module shift_sched #(
  parameter int  WIDTH = 32,
  parameter int  STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [SHW-1:0]   req1_shamt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0]     OP_SLL = 2'b00;
  localparam logic [1:0]     OP_SRL = 2'b01;
  localparam logic [1:0]     OP_SRA = 2'b10;
  localparam logic [SHW-1:0] STEP_R = SHW'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, res_data_q;
  logic [SHW-1:0]   rem_q;
  logic [1:0]       op_q;
  logic             tag_q, last_grant_q, res_tag_q;

  logic             any_valid, grant, accept;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [SHW-1:0]   shamt_sel;
  logic [SHW-1:0]   k, rem_next;
  logic [WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] rol_wide;

  // Arbitration. When both requesters are valid, the one that was not
  // served last wins. last_grant resets to 1, so requester 0 wins the
  // first contention.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
    // The rst_n term keeps both readies low while reset is asserted,
    // including before the first clock edge.
    req0_ready = rst_n && (state_q == IDLE) && any_valid && !grant;
    req1_ready = rst_n && (state_q == IDLE) && any_valid &&  grant;
    accept     = req0_ready | req1_ready;
    op_sel     = grant ? req1_op    : req0_op;
    a_sel      = grant ? req1_a     : req0_a;
    shamt_sel  = grant ? req1_shamt : req0_shamt;
  end

  // One shift step of k = min(rem, STEP) positions.
  always_comb begin
    k        = (rem_q < STEP_R) ? rem_q : STEP_R;
    rem_next = rem_q - k;
    // Rotate via a double-width copy, so that k = 0 needs no special case.
    rol_wide = {acc_q, acc_q} << k;
    case (op_q)
      OP_SLL:  shifted = acc_q << k;
      OP_SRL:  shifted = acc_q >> k;
      OP_SRA:  shifted = $unsigned($signed(acc_q) >>> k);
      default: shifted = rol_wide[2*WIDTH-1:WIDTH];
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (shamt_sel == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_next == '0) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath. res_data and res_tag are loaded only on entry to DONE. They
  // therefore stay stable through DONE and keep their value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      rem_q        <= '0;
      op_q         <= '0;
      tag_q        <= 1'b0;
      last_grant_q <= 1'b1;
      res_data_q   <= '0;
      res_tag_q    <= 1'b0;
    end else if (accept) begin
      acc_q        <= a_sel;
      rem_q        <= shamt_sel;
      op_q         <= op_sel;
      tag_q        <= grant;
      last_grant_q <= grant;
      if (shamt_sel == '0) begin
        res_data_q <= a_sel;
        res_tag_q  <= grant;
      end
    end else if (state_q == SHIFT) begin
      acc_q <= shifted;
      rem_q <= rem_next;
      if (rem_next == '0) begin
        res_data_q <= shifted;
        res_tag_q  <= tag_q;
      end
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sched.sv
`timescale 1ns/1ps
// Directed testbench for shift_sched (WIDTH=32, STEP=4). Inputs are driven
// and outputs sampled 1-2 time units after the rising clock edge.
module tb_shift_sched;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req1_a = '0;
  logic [4:0]   req0_shamt = '0, req1_shamt = '0;
  logic         res_valid, res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_tag, busy;

  int checks = 0;
  int passes = 0;

  shift_sched #(.WIDTH(W), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_shamt(req1_shamt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Present one request, wait (bounded) for ready, and let it be accepted.
  // Returns at 1 time unit after the accept edge, with valid dropped.
  task automatic issue(input string name, input int n, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [4:0] sh);
    int cnt = 0;
    if (n == 0) begin
      req0_op = op; req0_a = a; req0_shamt = sh; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_shamt = sh; req1_valid = 1'b1;
    end
    #1;
    while (((n == 0) ? req0_ready : req1_ready) !== 1'b1 && cnt < 30) begin
      @(posedge clk); #2; cnt++;
    end
    checks++;
    if (cnt >= 30) $display("FAIL %s_accept: ready never rose for requester %0d", name, n);
    else passes++;
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Wait for res_valid and measure latency in cycles from the accept cycle.
  // Called 1 time unit after the accept edge. If res_ready is high, the task
  // also consumes the result.
  task automatic wait_result(input string name, input logic [W-1:0] exp_data,
                             input logic exp_tag, input int exp_lat);
    int lat = 1;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== exp_lat) $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    else passes++;
    checks++;
    if (res_data !== exp_data) $display("FAIL %s_data: got %h, expected %h", name, res_data, exp_data);
    else passes++;
    checks++;
    if (res_tag !== exp_tag) $display("FAIL %s_tag: got %0d, expected %0d", name, res_tag, exp_tag);
    else passes++;
    if (res_ready === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({res_valid, res_tag, busy, req0_ready, req1_ready} !== 5'b0)
      $display("FAIL reset_ctrl: got v=%b t=%b busy=%b r0=%b r1=%b, expected all 0",
               res_valid, res_tag, busy, req0_ready, req1_ready);
    else passes++;
    checks++;
    if (res_data !== '0) $display("FAIL reset_data: got %h, expected 0", res_data);
    else passes++;
  endtask

  task automatic test_sll();
    issue("sll", 0, 2'b00, 32'h0000_0001, 5'd13);
    checks++;
    if ({req0_ready, busy} !== 2'b01)
      $display("FAIL sll_ready_pulse: got ready=%b busy=%b, expected ready=0 busy=1", req0_ready, busy);
    else passes++;
    wait_result("sll", 32'h0000_2000, 1'b0, 5);
  endtask

  task automatic test_sra_srl();
    issue("sra31", 1, 2'b10, 32'h8000_0000, 5'd31);
    wait_result("sra31", 32'hFFFF_FFFF, 1'b1, 9);
    issue("srl31", 1, 2'b01, 32'h8000_0000, 5'd31);
    wait_result("srl31", 32'h0000_0001, 1'b1, 9);
    issue("sra_pos", 0, 2'b10, 32'h4000_0000, 5'd30);
    wait_result("sra_pos", 32'h0000_0001, 1'b0, 9);
  endtask

  task automatic test_rol_zero();
    issue("rol4", 0, 2'b11, 32'h8000_0001, 5'd4);
    wait_result("rol4", 32'h0000_0018, 1'b0, 2);
    issue("rol31", 0, 2'b11, 32'h0000_0001, 5'd31);
    wait_result("rol31", 32'h8000_0000, 1'b0, 9);
    issue("sll5", 1, 2'b00, 32'h0000_00FF, 5'd5);
    wait_result("sll5", 32'h0000_1FE0, 1'b1, 3);
    issue("sra0", 1, 2'b10, 32'h1234_5678, 5'd0);
    wait_result("sra0", 32'h1234_5678, 1'b1, 1);
    issue("rol0", 0, 2'b11, 32'h1234_5678, 5'd0);
    wait_result("rol0", 32'h1234_5678, 1'b0, 1);
  endtask

  task automatic test_contention();
    logic [W-1:0] exp_q[$];
    logic         exp_tag_q[$];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h0000_0010);  exp_tag_q.push_back(1'b0);
      exp_q.push_back(32'h0080_0000);  exp_tag_q.push_back(1'b1);
    end
    req0_op = 2'b00; req0_a = 32'h0000_0001; req0_shamt = 5'd4; req0_valid = 1'b1;
    req1_op = 2'b01; req1_a = 32'h8000_0000; req1_shamt = 5'd8; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int cnt = 0;
      logic [W-1:0] ed;
      logic         et;
      ed = exp_q.pop_front();
      et = exp_tag_q.pop_front();
      @(posedge clk); #1;
      while (res_valid !== 1'b1 && cnt < 20) begin
        @(posedge clk); #1; cnt++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_tag !== et || res_data !== ed)
        $display("FAIL contention_%0d: got v=%b tag=%0d data=%h, expected tag=%0d data=%h",
                 i, res_valid, res_tag, res_data, et, ed);
      else passes++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    res_ready = 1'b0;
    issue("bp", 0, 2'b00, 32'h0000_00A5, 5'd4);
    wait_result("bp", 32'h0000_0A50, 1'b0, 2);
    req1_op = 2'b01; req1_a = 32'hF000_0000; req1_shamt = 5'd4; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({res_valid, res_tag, req0_ready, req1_ready, busy} !== 5'b10001 ||
          res_data !== 32'h0000_0A50)
        $display("FAIL bp_hold_%0d: got v=%b t=%b r0=%b r1=%b busy=%b data=%h, expected v=1 t=0 r0=0 r1=0 busy=1 data=00000a50",
                 i, res_valid, res_tag, req0_ready, req1_ready, busy, res_data);
      else passes++;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({res_valid, req1_ready, busy} !== 3'b010 || res_data !== 32'h0000_0A50)
      $display("FAIL bp_release: got v=%b r1=%b busy=%b data=%h, expected v=0 r1=1 busy=0 data=00000a50",
               res_valid, req1_ready, busy, res_data);
    else passes++;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_result("bp_next", 32'h0F00_0000, 1'b1, 2);
  endtask

  task automatic test_reset_mid_shift();
    issue("rst_op", 0, 2'b10, 32'h8000_0000, 5'd31);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Third SHIFT cycle. Present contending requests, then reset between edges.
    req0_op = 2'b00; req0_a = 32'h0000_0001; req0_shamt = 5'd2; req0_valid = 1'b1;
    req1_op = 2'b01; req1_a = 32'h0000_0080; req1_shamt = 5'd2; req1_valid = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b, expected 1", busy);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, busy, req0_ready, req1_ready} !== 4'b0000)
      $display("FAIL rst_async: got v=%b busy=%b r0=%b r1=%b, expected all 0",
               res_valid, busy, req0_ready, req1_ready);
    else passes++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({res_valid, req0_ready, req1_ready} !== 3'b010)
      $display("FAIL rst_regrant: got v=%b r0=%b r1=%b, expected v=0 r0=1 r1=0",
               res_valid, req0_ready, req1_ready);
    else passes++;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_result("rst_new", 32'h0000_0004, 1'b0, 2);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_sll();
    test_sra_srl();
    test_rol_zero();
    test_contention();
    test_back_pressure();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Shared iterative shift engine with a two-requester round-robin arbiter for the RISC core.
- Requester 0 is the integer ALU issue path; requester 1 is the multiply/divide sequencer.
- Each accepted operation is processed at most STEP bit-positions per cycle until the full shift amount is consumed, then the result is held until consumed.
- Replaces per-requester combinational shifters with one area-cheap multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STEP, 4, maximum bit-positions shifted per cycle; legal range 1..WIDTH-1.
- SHW, $clog2(WIDTH) (localparam), shift-amount width (5 at default).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
- req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- req0_a  in  WIDTH  operand.
- req0_shamt  in  SHW  shift amount.
- req1_valid, req1_ready, req1_op, req1_a, req1_shamt: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  WIDTH  shifted result.
- res_tag  out  1  index of the requester that owns res_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: state=IDLE; res_valid=0; res_data=0; res_tag=0; busy=0; last_grant=1, so requester 0 wins the first contention.
- Reset asserted mid-operation aborts immediately. The in-flight op is lost and no result is produced.
- FSM states: IDLE, SHIFT, DONE.

IDLE:
- grant = req0 if only req0_valid.
- grant = req1 if only req1_valid.
- If both are valid, grant = the requester not equal to last_grant.
- reqN_ready = (state==IDLE) && grant==N, combinational from the valids.
- Readies are never both high. Both readies are low outside IDLE.
- On accept:
  - Latch op, a, shamt (as rem) and tag=N.
  - last_grant <= N.
  - If shamt==0, go to DONE with result = a unmodified; otherwise go to SHIFT.

SHIFT, each cycle:
- k = min(rem, STEP).
- acc <= acc shifted by k per op:
  - SLL: zero fill from the right.
  - SRL: zero fill from the left.
  - SRA: sign-bit fill, sign taken from the current acc MSB; this is equivalent to the original sign.
  - ROL: bits leaving the MSB re-enter at the LSB.
- rem <= rem - k.
- When rem - k == 0, go to DONE.
- SHIFT occupancy = ceil(shamt/STEP) cycles; maximum ceil((WIDTH-1)/STEP) = 8 at defaults.

DONE:
- res_valid=1; res_data, res_tag stable.
- On res_valid&&res_ready, go to IDLE; res_valid drops the next cycle.
- res_data retains its last value after the handshake (not cleared).
- If res_ready is low, hold indefinitely. Back-pressure stalls both requesters.
- A request asserted during DONE is not accepted until the cycle after the result handshake; there is no overlap.

Latency:
- Accept edge to res_valid high = ceil(shamt/STEP)+1 cycles for shamt>0.
- Latency is 1 cycle for shamt==0.

Input rules:
- Inputs are sampled only at the accept edge. Changes to reqN_* afterwards have no effect on the op in flight.
- reqN_valid may drop without a handshake and is not required to be held.

Arithmetic:
- All arithmetic is unsigned on rem.
- The SRA fill uses bit WIDTH-1 of acc.
- No results are undefined for any op/shamt combination.

Test Plan:
- SLL, req0 only: a=0x0000_0001, shamt=13, res_ready=1 -> ready pulses 1 cycle; res_valid exactly 5 cycles after accept; res_data=0x0000_2000; tag=0.
- SRA, req1 only: a=0x8000_0000, shamt=31 -> 8 SHIFT cycles; res_data=0xFFFF_FFFF; tag=1. SRL with the same operands -> 0x0000_0001.
- ROL and shamt=0:
  - ROL a=0x8000_0001, shamt=4 -> res_data=0x0000_0018, 2 cycles after accept.
  - Any op with shamt=0 and a=0x1234_5678 -> res_data=0x1234_5678, 1 cycle after accept.
- Contention: req0 and req1 held valid continuously with distinct operands -> grants alternate 0,1,0,1 starting with 0; res_tag alternates accordingly; no request is starved.
- Back-pressure:
  - Hold res_ready=0 for 10 cycles in DONE -> res_valid, res_data, res_tag stable; both readies low; busy=1.
  - Release res_ready -> IDLE next cycle; the pending request is accepted in that IDLE cycle.
- Reset mid-SHIFT: assert rst_n=0 asynchronously (between edges) during op 3 of 8 -> res_valid, busy and readies go low immediately without a clock edge. After release, a new op completes correctly and the next contention grants requester 0.
